// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM block: mode encodings and
// the counting-direction type used by the period counter.
package pwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_t;

endpackage

// File: rtl/pwm_counter.sv
// Shared period counter. Counts 0..top and wraps in edge mode, or
// triangles 0..top..1 in center mode. It flags the last cycle of each
// period so the owner can swap in new settings. The counter always
// re-enters a period at 0 counting up.
module pwm_counter
   import pwm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] top,
   input  logic             mode,
   output logic [WIDTH-1:0] ctr,
   output logic             boundary
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   pwm_dir_t         dir;
   pwm_dir_t         dir_nxt;
   logic [WIDTH-1:0] ctr_nxt;

   // Next counter value, next direction and last-cycle-of-period detection
   always_comb begin
      boundary = 1'b0;
      ctr_nxt  = ctr;
      dir_nxt  = dir;
      if (top == ZERO) begin
         // Degenerate period: parked at 0, every cycle ends a period
         boundary = 1'b1;
         ctr_nxt  = ZERO;
         dir_nxt  = DIR_UP;
      end else if (mode == MODE_EDGE) begin
         if (ctr == top) begin
            boundary = 1'b1;
            ctr_nxt  = ZERO;
         end else begin
            ctr_nxt  = ctr + ONE;
         end
         dir_nxt = DIR_UP;
      end else begin
         case (dir)
            DIR_UP: begin
               if (ctr != top) begin
                  ctr_nxt = ctr + ONE;
               end else if (top == ONE) begin
                  // top=1: the peak is also the last value of the period
                  boundary = 1'b1;
                  ctr_nxt  = ZERO;
               end else begin
                  ctr_nxt = ctr - ONE;
                  dir_nxt = DIR_DOWN;
               end
            end
            DIR_DOWN: begin
               if (ctr == ONE) begin
                  boundary = 1'b1;
                  ctr_nxt  = ZERO;
                  dir_nxt  = DIR_UP;
               end else begin
                  ctr_nxt = ctr - ONE;
               end
            end
            default: begin
               ctr_nxt = ZERO;
               dir_nxt = DIR_UP;
            end
         endcase
      end
   end

   // Counter and direction state; frozen while disabled
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr <= ZERO;
         dir <= DIR_UP;
      end else if (en) begin
         ctr <= ctr_nxt;
         dir <= dir_nxt;
      end else begin
         ctr <= ctr;
         dir <= dir;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator. One shared period counter drives CHANNELS
// comparators. Duty/top/mode writes land in a shadow set first. They reach
// the active set only on the last cycle of a period, so a running pulse is
// never cut short. A write on that very cycle goes straight to active.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [WIDTH-1:0]          top,
   input  logic                      mode,
   input  logic [CHANNELS*WIDTH-1:0] duty,
   input  logic                      wr,
   output logic                      pending,
   output logic                      period_start,
   output logic [CHANNELS-1:0]       pwm
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   logic [CHANNELS*WIDTH-1:0] sh_duty;
   logic [WIDTH-1:0]          sh_top;
   logic                      sh_mode;
   logic [CHANNELS*WIDTH-1:0] act_duty;
   logic [WIDTH-1:0]          act_top;
   logic                      act_mode;

   logic [WIDTH-1:0]          ctr;
   logic                      boundary;
   logic [CHANNELS-1:0]       pwm_nxt;

   pwm_counter #(
      .WIDTH (WIDTH)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .top      (act_top),
      .mode     (act_mode),
      .ctr      (ctr),
      .boundary (boundary)
   );

   // Shadow capture, period-end transfer to active, and pending tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_duty  <= {(CHANNELS*WIDTH){1'b0}};
         sh_top   <= {WIDTH{1'b1}};
         sh_mode  <= MODE_EDGE;
         act_duty <= {(CHANNELS*WIDTH){1'b0}};
         act_top  <= {WIDTH{1'b1}};
         act_mode <= MODE_EDGE;
         pending  <= 1'b0;
      end else begin
         if (wr) begin
            sh_duty <= duty;
            sh_top  <= top;
            sh_mode <= mode;
         end
         if (en && boundary) begin
            // A write landing on the boundary bypasses the shadow
            if (wr) begin
               act_duty <= duty;
               act_top  <= top;
               act_mode <= mode;
            end else begin
               act_duty <= sh_duty;
               act_top  <= sh_top;
               act_mode <= sh_mode;
            end
            pending <= 1'b0;
         end else if (wr) begin
            pending <= 1'b1;
         end else begin
            pending <= pending;
         end
      end
   end

   // Per-channel compare; a duty above top forces a constant high
   for (genvar i = 0; i < CHANNELS; i++) begin : g_cmp
      assign pwm_nxt[i] = (ctr < act_duty[i*WIDTH +: WIDTH]) ||
                          (act_duty[i*WIDTH +: WIDTH] > act_top);
   end

   // Registered outputs: one-cycle lag behind the counter, frozen while disabled
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm          <= {CHANNELS{1'b0}};
         period_start <= 1'b0;
      end else if (en) begin
         pwm          <= pwm_nxt;
         period_start <= (ctr == ZERO);
      end else begin
         pwm          <= pwm;
         period_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (CHANNELS=4, WIDTH=8). A period-position
// model predicts pwm/period_start/pending/ctr every cycle. Hand-computed
// literal checks pin the model on the planned scenarios.
module tb_pwm_multi;

   localparam int CH = 4;
   localparam int W  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic [W-1:0]    in_top;
   logic            in_mode;
   logic [CH*W-1:0] duty;
   logic            wr;
   logic            pending;
   logic            period_start;
   logic [CH-1:0]   pwm;

   int vectors     = 0;
   int miscompares = 0;
   bit checking    = 1'b0;
   int cyc         = 0;

   // model state
   int m_duty [CH];
   int m_sh_duty [CH];
   int m_top, m_sh_top, m_mode, m_sh_mode;
   int m_phase, m_pending, m_ctr;
   bit [CH-1:0] m_pwm;
   bit m_ps;

   // window tallies
   int w_hi [CH];
   int w_ps, w_pend;

   pwm_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .top          (in_top),
      .mode         (in_mode),
      .duty         (duty),
      .wr           (wr),
      .pending      (pending),
      .period_start (period_start),
      .pwm          (pwm)
   );

   always #5 clk = ~clk;

   // cycle counter used to measure period lengths
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int plen();
      if (m_top == 0) return 1;
      if (m_mode == 0) return m_top + 1;
      return 2 * m_top;
   endfunction

   function automatic int ctr_of(input int p);
      if (m_mode == 0 || p <= m_top) return p;
      return 2 * m_top - p;
   endfunction

   // behavioural model: position within the period, advanced per enabled cycle
   always @(posedge clk) begin
      int  c;
      bit  bnd;
      if (rst) begin
         for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            m_sh_duty[i] = 0;
         end
         m_top = 255; m_sh_top = 255; m_mode = 0; m_sh_mode = 0;
         m_phase = 0; m_pending = 0; m_pwm = '0; m_ps = 1'b0;
      end else begin
         c   = ctr_of(m_phase);
         bnd = en && (m_phase == plen() - 1);
         if (en) begin
            for (int i = 0; i < CH; i++)
               m_pwm[i] = (c < m_duty[i]) || (m_duty[i] > m_top);
            m_ps = (c == 0);
         end else begin
            m_ps = 1'b0;
         end
         if (bnd) begin
            for (int i = 0; i < CH; i++)
               m_duty[i] = wr ? int'(duty[i*W +: W]) : m_sh_duty[i];
            m_top  = wr ? int'(in_top)  : m_sh_top;
            m_mode = wr ? int'(in_mode) : m_sh_mode;
            m_pending = 0;
         end else if (wr) begin
            m_pending = 1;
         end
         if (wr) begin
            for (int i = 0; i < CH; i++) m_sh_duty[i] = int'(duty[i*W +: W]);
            m_sh_top  = int'(in_top);
            m_sh_mode = int'(in_mode);
         end
         if (en) m_phase = bnd ? 0 : m_phase + 1;
      end
      m_ctr = ctr_of(m_phase);
   end

   // per-cycle compare against the model
   always @(posedge clk) begin
      #1;
      if (checking) begin
         chk("pwm", int'(pwm), int'(m_pwm));
         chk("period_start", int'(period_start), int'(m_ps));
         chk("pending", int'(pending), m_pending);
         chk("ctr", int'(dut.u_counter.ctr), m_ctr);
      end
   end

   task automatic drive_wr(input logic [W-1:0] t, input logic md, input logic [CH*W-1:0] d);
      @(negedge clk);
      in_top = t; in_mode = md; duty = d; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic wait_ps(input int budget);
      int k = 0;
      do begin
         @(posedge clk); #1; k++;
      end while (!period_start && k < budget);
      chk("wait_period_start", int'(period_start), 1);
   endtask

   task automatic wait_pending_clear(input int budget);
      int k = 0;
      do begin
         @(posedge clk); #1; k++;
      end while (pending && k < budget);
      chk("wait_pending_clear", int'(pending), 0);
   endtask

   // tally n output samples; optionally pulse wr with new duty after sample wr_at
   task automatic window(input int n, input int wr_at, input logic [CH*W-1:0] wd);
      for (int i = 0; i < CH; i++) w_hi[i] = 0;
      w_ps = 0; w_pend = 0;
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < CH; c++) w_hi[c] += int'(pwm[c]);
         w_ps   += int'(period_start);
         w_pend += int'(pending);
         if (k == wr_at) begin
            @(negedge clk); duty = wd; wr = 1'b1;
         end else if (wr) begin
            @(negedge clk); wr = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [CH*W-1:0] d_init, d7, d5, d8, d_ctr;
      logic [7:0] pat;
      int cv [8];
      int exp_cv [8];
      int s0, hi2, hi3;
      int k;
      exp_cv = '{1, 2, 3, 4, 3, 2, 1, 0};
      d_init = {8'd9, 8'd10, 8'd0, 8'd3};
      d7     = {8'd9, 8'd10, 8'd0, 8'd7};
      d5     = {8'd9, 8'd10, 8'd0, 8'd5};
      d8     = {8'd9, 8'd10, 8'd0, 8'd8};
      d_ctr  = {8'd4, 8'd5, 8'd0, 8'd2};

      rst = 1'b1; en = 1'b0; wr = 1'b0; in_top = 8'd0; in_mode = 1'b0; duty = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; checking = 1'b1;
      @(posedge clk); #1;
      chk("reset_pwm", int'(pwm), 0);
      chk("reset_ps", int'(period_start), 0);
      chk("reset_pending", int'(pending), 0);
      chk("reset_act_top", int'(dut.act_top), 255);

      // load edge top=9 while disabled, then enable
      @(negedge clk);
      in_top = 8'd9; in_mode = 1'b0; duty = d_init; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0; en = 1'b1;
      chk("pending_after_wr", int'(pending), 1);
      @(posedge clk); #1;
      chk("first_ps", int'(period_start), 1);
      wait_pending_clear(300);
      wait_ps(20);

      // edge-mode duty ratios
      window(10, -1, '0);
      chk("edge_ch0_high", w_hi[0], 3);
      chk("edge_ch1_high", w_hi[1], 0);
      chk("edge_ch2_high", w_hi[2], 10);
      chk("edge_ch3_high", w_hi[3], 9);
      chk("edge_ps_count", w_ps, 1);
      chk("edge_period10_ps", int'(period_start), 1);

      // mid-period write at ctr=4
      window(10, 3, d7);
      chk("mid_old_duty", w_hi[0], 3);
      chk("mid_pending_cycles", w_pend, 5);
      chk("mid_next_ps", int'(period_start), 1);
      chk("mid_pending_clear", int'(pending), 0);
      window(10, -1, '0);
      chk("mid_new_duty", w_hi[0], 7);

      // write exactly on the boundary (ctr=9)
      window(10, 8, d5);
      chk("bnd_old_duty", w_hi[0], 7);
      chk("bnd_no_pending", w_pend, 0);
      chk("bnd_next_ps", int'(period_start), 1);
      window(10, -1, '0);
      chk("bnd_new_duty", w_hi[0], 5);
      chk("bnd_no_pending2", w_pend, 0);

      // enable hold of 5 cycles with a write during the hold
      s0 = cyc;
      window(4, -1, '0);
      chk("hold_pre_pwm0", int'(pwm[0]), 1);
      @(negedge clk);
      en = 1'b0; duty = d8; wr = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      wr = 1'b0;
      chk("hold_pwm0", int'(pwm[0]), 1);
      chk("hold_pending", int'(pending), 1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("hold_ctr", int'(dut.u_counter.ctr), 5);
      en = 1'b1;
      wait_ps(30);
      chk("hold_period_len", cyc - s0, 15);
      window(10, -1, '0);
      chk("hold_new_duty", w_hi[0], 8);

      // center mode top=4
      drive_wr(8'd4, 1'b1, d_ctr);
      wait_pending_clear(30);
      wait_ps(30);
      hi2 = 0; hi3 = 0;
      for (int i = 0; i < 8; i++) begin
         pat[i] = pwm[0];
         cv[i]  = int'(dut.u_counter.ctr);
         hi2 += int'(pwm[2]);
         hi3 += int'(pwm[3]);
         @(posedge clk); #1;
      end
      chk("center_pattern", int'(pat), 8'b1000_0011);
      for (int i = 0; i < 8; i++) chk("center_ctr_seq", cv[i], exp_cv[i]);
      chk("center_ch2_high", hi2, 8);
      chk("center_ch3_high", hi3, 7);
      chk("center_period8_ps", int'(period_start), 1);

      // reset mid-period with a pending write
      drive_wr(8'd9, 1'b0, d_init);
      wait_pending_clear(30);
      drive_wr(8'd9, 1'b0, d7);
      k = 0;
      while (m_ctr != 6 && k < 20) begin
         @(posedge clk); #1; k++;
      end
      chk("rst_reach_ctr6", int'(dut.u_counter.ctr), 6);
      chk("rst_pre_pending", int'(pending), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_pwm", int'(pwm), 0);
      chk("rst_pending", int'(pending), 0);
      chk("rst_ps", int'(period_start), 0);
      chk("rst_act_top", int'(dut.act_top), 255);
      chk("rst_ctr", int'(dut.u_counter.ctr), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
